card_dealer: RTL and testbench
==============================

# card_dealer

Parametrised card-draw engine for the multi-player card game datapath. It rotates turns among `NUM_PLAYERS` players and generates card values from a free-running 8-bit LFSR, mapping them to a bounded colour and number. It also tracks per-player hand counts and refuses draws into a full hand. It replaces the fixed two-player turn, counter, random and card-value chain with one sequenced block feeding the display and score logic.

## Interface
Parameters:
- `NUM_PLAYERS`, default 2: number of players, legal range 2..4.
- `NUM_COLORS`, default 3: number of colours, legal range 2..4.
- `NUM_NUMBERS`, default 5: number of card numbers, legal range 4..7.
- `MAX_HAND`, default 15: maximum cards per hand, legal range 1..15.
- `SEED`, default 8'hE1: LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `draw` in 1: request one card for the current player; sampled in IDLE only.
- `pass` in 1: end the current turn; sampled in IDLE only.
- `finish` in 1: clear the game state synchronously.
- `whose` out 2: index of the current player, 0..NUM_PLAYERS-1.
- `card_valid` out 1: one-cycle pulse when a card is dealt.
- `card_color` out 3: colour of the last dealt card, 1..NUM_COLORS; held between deals.
- `card_number` out 3: number of the last dealt card, 1..NUM_NUMBERS; held between deals.
- `card_owner` out 2: player who received the last dealt card.
- `hand_count` out NUM_PLAYERS*4: packed per-player counts; player p occupies bits [4p+3:4p].
- `hand_full` out 1: one-cycle pulse when a draw is refused.
- `turn_pulse` out 1: one-cycle pulse when `whose` advances.
- `busy` out 1: high while in state DRAW.
- `rnd` out 8: current LFSR value, exposed for verification.

## Operation
- LFSR: 8-bit Fibonacci register. Shifts left every clock outside reset. New bit0 = q[7]^q[5]^q[4]^q[3] (maximal length, period 255).
- Candidate fields, taken from the pre-edge value of `rnd`: c = rnd[4:3], n = rnd[2:0].
- Fold rule:
  - cf = (c >= NUM_COLORS) ? c-NUM_COLORS : c.
  - nf = (n >= NUM_NUMBERS) ? n-NUM_NUMBERS : n.
  - Card value is colour cf+1, number nf+1.
- FSM has two states, IDLE and DRAW.
- IDLE:
  - `draw` with hand_count[whose] < MAX_HAND: go to DRAW and clear the try counter.
  - `draw` with hand_count[whose] == MAX_HAND: pulse `hand_full`, stay in IDLE, counts unchanged.
  - `pass` without `draw`: `whose` <= (whose == NUM_PLAYERS-1) ? 0 : whose+1, and pulse `turn_pulse`.
  - `draw` and `pass` together: `draw` wins and `pass` is dropped.
- DRAW, at each edge:
  - Evaluate c and n and decide whether to accept (see Configuration).
  - On accept: latch `card_color`, `card_number`, and `card_owner` = whose; pulse `card_valid`; increment hand_count[whose]; return to IDLE.
  - Otherwise: increment the try counter (3 bits) and stay in DRAW.
  - `draw` and `pass` are ignored while in DRAW.
- `finish` (any state, priority over all inputs except reset):
  - All hand counts go to 0, `whose` goes to 0, state goes to IDLE.
  - Any pending draw is abandoned with no `card_valid`.
  - The LFSR keeps running and is not reseeded.
- Reset values:
  - `rnd` = SEED.
  - All other outputs = 0: `whose`, `card_valid`, `card_color`, `card_number`, `card_owner`, `hand_count`, `hand_full`, `turn_pulse`, `busy`.
  - State = IDLE, try counter = 0.
  - Reset in the middle of a DRAW aborts it with no pulse.

## Timing
- All outputs are registered.
- `draw` sampled at edge k: `busy` is high after edge k.
- The first accept opportunity is edge k+1, so `card_valid` and the incremented `hand_count` are high from edge k+1 to edge k+2.
- Worst case with rejection: `card_valid` after edge k+8 (tries 0..7, forced accept on try 7).
- `hand_full` and `turn_pulse` are high for the one cycle after the sampling edge.
- A new `draw` is accepted in the cycle after `card_valid`.

## Configuration
- `CARD_DEALER_REJECT_EN` defined: rejection sampling.
  - Accept only when c < NUM_COLORS and n < NUM_NUMBERS.
  - On try 7, accept unconditionally using the fold rule.
  - Latency is variable, 1..8 cycles.
- Undefined: always accept on the first DRAW edge using the fold rule. Latency is fixed at 1 cycle.

## Test plan
- Reset check: hold `rst`=0 for 3 cycles with SEED=8'hE1 -> all outputs 0, `rnd`=8'hE1; one cycle after release `rnd`=8'hC2.
- Turn rotation: NUM_PLAYERS=3, three single-cycle `pass` pulses -> `whose` goes 1, 2, 0, with one `turn_pulse` each.
- Full hand: MAX_HAND=2, three draws by player 0 -> two `card_valid` pulses, hand_count[3:0]=2, then a `hand_full` pulse with counts unchanged.
- Simultaneous inputs: `draw`=`pass`=1 in IDLE -> one `card_valid`, `card_owner`=0, `whose` stays 0, no `turn_pulse`.
- Value check (macro off): bench models the LFSR from SEED; on each `card_valid`, `card_color` and `card_number` equal the fold of the pre-edge `rnd`; 200 draws all in range.
- Mid-draw finish (macro on): assert `finish` on the edge after `draw` -> no `card_valid`, `busy`=0, all counts 0, `whose`=0.

Source files
------------

// File: rtl/card_dealer.sv
// card_dealer: turn rotation, LFSR-driven card generation and per-player hand tracking.
// Optional CARD_DEALER_REJECT_EN selects rejection sampling (up to 8 tries) instead of a 1-cycle fold.
module card_dealer #(
    parameter int          NUM_PLAYERS = 2,
    parameter int          NUM_COLORS  = 3,
    parameter int          NUM_NUMBERS = 5,
    parameter int          MAX_HAND    = 15,
    parameter logic [7:0]  SEED        = 8'hE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     draw,
    input  logic                     pass,
    input  logic                     finish,
    output logic [1:0]               whose,
    output logic                     card_valid,
    output logic [2:0]               card_color,
    output logic [2:0]               card_number,
    output logic [1:0]               card_owner,
    output logic [NUM_PLAYERS*4-1:0] hand_count,
    output logic                     hand_full,
    output logic                     turn_pulse,
    output logic                     busy,
    output logic [7:0]               rnd
);

    typedef enum logic {IDLE, DRAW} state_t;

    localparam logic [2:0] NC3    = 3'(NUM_COLORS);
    localparam logic [2:0] NN3    = 3'(NUM_NUMBERS);
    localparam logic [3:0] MAX4   = 4'(MAX_HAND);
    localparam logic [1:0] LAST_P = 2'(NUM_PLAYERS - 1);

    state_t state, state_next;

    logic [3:0]               cur_count;
    logic                     start_draw, refuse, do_pass, accept;
    logic [2:0]               c_ext, n_ext, color_fold, number_fold;
    logic [1:0]               whose_next;
    logic [NUM_PLAYERS*4-1:0] counts_next;
    logic                     card_valid_next, hand_full_next, turn_pulse_next;

    // Free-running; finish deliberately does not reseed it.
    always_ff @(posedge clk) begin
        if (!rst)
            rnd <= SEED;
        else
            rnd <= {rnd[6:0], rnd[7] ^ rnd[5] ^ rnd[4] ^ rnd[3]};
    end

    always_comb begin
        cur_count = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++)
            if (whose == 2'(p))
                cur_count = hand_count[4*p +: 4];
    end

    assign c_ext       = {1'b0, rnd[4:3]};
    assign n_ext       = rnd[2:0];
    assign color_fold  = (c_ext >= NC3) ? c_ext - NC3 : c_ext;
    assign number_fold = (n_ext >= NN3) ? n_ext - NN3 : n_ext;

    assign start_draw = (state == IDLE) && draw && (cur_count < MAX4);
    assign refuse     = (state == IDLE) && draw && !(cur_count < MAX4);
    assign do_pass    = (state == IDLE) && pass && !draw;

`ifdef CARD_DEALER_REJECT_EN
    logic [2:0] tries;
    logic       in_range;

    assign in_range = (c_ext < NC3) && (n_ext < NN3);
    assign accept   = (state == DRAW) && (in_range || (tries == 3'd7));

    always_ff @(posedge clk) begin
        if (!rst || finish || start_draw)
            tries <= '0;
        else if ((state == DRAW) && !accept)
            tries <= tries + 3'd1;
    end
`else
    assign accept = (state == DRAW);
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start_draw) state_next = DRAW;
            DRAW: if (accept)     state_next = IDLE;
            default:              state_next = IDLE;
        endcase
        if (finish)
            state_next = IDLE;
    end

    always_comb begin
        card_valid_next = accept && !finish;
        hand_full_next  = refuse && !finish;
        turn_pulse_next = do_pass && !finish;
        whose_next      = whose;
        counts_next     = hand_count;
        if (do_pass)
            whose_next = (whose == LAST_P) ? '0 : whose + 2'd1;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++)
            if (accept && (whose == 2'(p)))
                counts_next[4*p +: 4] = hand_count[4*p +: 4] + 4'd1;
        if (finish) begin
            whose_next  = '0;
            counts_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            whose       <= '0;
            card_valid  <= 1'b0;
            card_color  <= '0;
            card_number <= '0;
            card_owner  <= '0;
            hand_count  <= '0;
            hand_full   <= 1'b0;
            turn_pulse  <= 1'b0;
        end else begin
            whose      <= whose_next;
            card_valid <= card_valid_next;
            hand_count <= counts_next;
            hand_full  <= hand_full_next;
            turn_pulse <= turn_pulse_next;
            if (card_valid_next) begin
                card_color  <= color_fold + 3'd1;
                card_number <= number_fold + 3'd1;
                card_owner  <= whose;
            end
        end
    end

    assign busy = (state == DRAW);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed reset/turn/full-hand/finish steps plus random draws
// checked against a transaction-level model of turns, hand counts and the LFSR card sequence.
module tb_card_dealer;
    localparam int         NP   = 3;
    localparam int         NC   = 3;
    localparam int         NN   = 5;
    localparam int         MH   = 2;
    localparam logic [7:0] SEED = 8'hE1;

    logic          clk = 1'b0, rst = 1'b0, draw = 1'b0, pass = 1'b0, finish = 1'b0;
    logic [1:0]    whose, card_owner;
    logic          card_valid, hand_full, turn_pulse, busy;
    logic [2:0]    card_color, card_number;
    logic [NP*4-1:0] hand_count;
    logic [7:0]    rnd;

    card_dealer #(.NUM_PLAYERS(NP), .NUM_COLORS(NC), .NUM_NUMBERS(NN), .MAX_HAND(MH), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .draw(draw), .pass(pass), .finish(finish),
        .whose(whose), .card_valid(card_valid), .card_color(card_color), .card_number(card_number),
        .card_owner(card_owner), .hand_count(hand_count), .hand_full(hand_full),
        .turn_pulse(turn_pulse), .busy(busy), .rnd(rnd)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_rnd;
    int         m_whose = 0;
    int         m_cnt[NP];
    int         dealt = 0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [NP*4-1:0] exp_hc();
        logic [NP*4-1:0] v;
        for (int p = 0; p < NP; p++) v[4*p +: 4] = 4'(m_cnt[p]);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model LFSR advances with it and outputs are sampled 1ns later.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        m_rnd = r ? lfsr_next(m_rnd) : SEED;
        #1;
    endtask

    task automatic pass_op();
        pass = 1'b1;
        tick();
        pass = 1'b0;
        m_whose = (m_whose + 1) % NP;
        chk("pass_whose", whose, m_whose);
        chk("pass_pulse", turn_pulse, 1);
        chk("pass_rnd", rnd, m_rnd);
        tick();
        chk("pass_pulse_off", turn_pulse, 0);
    endtask

    task automatic finish_op();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        m_whose = 0;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
        chk("fin_hc", hand_count, exp_hc());
        chk("fin_whose", whose, 0);
        chk("fin_busy", busy, 0);
        chk("fin_cv", card_valid, 0);
    endtask

    task automatic do_draw(input logic with_pass);
        logic       full, ok, found;
        logic [7:0] v;
        int         lat, ec, en;
        full = (m_cnt[m_whose] >= MH);
        draw = 1'b1;
        pass = with_pass;
        tick();
        draw = 1'b0;
        pass = 1'b0;
        chk("drw_turn", turn_pulse, 0);
        chk("drw_whose", whose, m_whose);
        if (full) begin
            chk("full_pulse", hand_full, 1);
            chk("full_busy", busy, 0);
            chk("full_hc", hand_count, exp_hc());
            tick();
            chk("full_pulse_off", hand_full, 0);
            chk("full_cv", card_valid, 0);
        end else begin
            chk("drw_busy", busy, 1);
            chk("drw_hf", hand_full, 0);
            v = m_rnd;
            found = 1'b0;
            lat = 8; ec = 0; en = 0;
            for (int t = 0; t < 8; t++) begin
`ifdef CARD_DEALER_REJECT_EN
                ok = ((int'(v[4:3]) < NC) && (int'(v[2:0]) < NN)) || (t == 7);
`else
                ok = 1'b1;
`endif
                if (ok && !found) begin
                    found = 1'b1;
                    lat = t + 1;
                    ec = int'(v[4:3]) % NC + 1;
                    en = int'(v[2:0]) % NN + 1;
                end
                v = lfsr_next(v);
            end
            for (int t = 1; t < lat; t++) begin
                tick();
                chk("cv_early", card_valid, 0);
            end
            tick();
            m_cnt[m_whose]++;
            chk("cv", card_valid, 1);
            chk("color", card_color, ec);
            chk("number", card_number, en);
            chk("owner", card_owner, m_whose);
            chk("hc", hand_count, exp_hc());
            chk("busy_done", busy, 0);
            chk("rnd", rnd, m_rnd);
            chk("color_rng", (card_color >= 1) && (card_color <= NC), 1);
            chk("number_rng", (card_number >= 1) && (card_number <= NN), 1);
            dealt++;
            tick();
            chk("cv_off", card_valid, 0);
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;

        // Reset held for three cycles
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rst_rnd", rnd, 8'hE1);
        chk("rst_whose", whose, 0);
        chk("rst_cv", card_valid, 0);
        chk("rst_color", card_color, 0);
        chk("rst_number", card_number, 0);
        chk("rst_owner", card_owner, 0);
        chk("rst_hc", hand_count, 0);
        chk("rst_hf", hand_full, 0);
        chk("rst_tp", turn_pulse, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        tick();
        chk("rnd_after_rst", rnd, 8'hC2);

        // Turn rotation 1, 2, 0
        pass_op(); chk("rot1", whose, 1);
        pass_op(); chk("rot2", whose, 2);
        pass_op(); chk("rot0", whose, 0);

        // Full hand for player 0
        do_draw(1'b0);
        do_draw(1'b0);
        chk("p0_two", hand_count[3:0], 2);
        do_draw(1'b0);
        chk("p0_still_two", hand_count[3:0], 2);

        // draw and pass together: draw wins
        finish_op();
        do_draw(1'b1);
        chk("simul_owner", card_owner, 0);
        chk("simul_whose", whose, 0);

        // Random play until 200 cards have been dealt
        for (int i = 0; i < 3000 && dealt < 203; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) pass_op();
            else if (r == 3) finish_op();
            else if (r == 4 && m_cnt[m_whose] >= MH) pass_op();
            do_draw(1'(($urandom_range(0, 7) == 0) ? 1 : 0));
        end
        chk("dealt_200", dealt >= 203, 1);

        // finish on the edge after draw abandons it
        finish_op();
        pass_op();
        draw = 1'b1;
        tick();
        draw = 1'b0;
        chk("mid_busy_on", busy, 1);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        m_whose = 0;
        chk("mid_cv", card_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_hc", hand_count, 0);
        chk("mid_whose", whose, 0);
        chk("mid_rnd", rnd, m_rnd);
        tick();
        chk("mid_cv_late", card_valid, 0);

        // Reset in the middle of a draw
        draw = 1'b1;
        tick();
        draw = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstmid_cv", card_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rnd", rnd, SEED);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
